imem_boot_loader: RTL and testbench
===================================

# imem_boot_loader

Loads a program into instruction memory from a byte stream and holds the CPU pipeline in reset until the image is complete and its checksum verifies. The block sits directly upstream of the fetch stage. It owns the instruction-memory byte write port and drives the pipeline's `RST` input. A bad or oversized image leaves the CPU held in reset and raises an error flag.

## Interface
Parameters:
- `MAX_WORDS`, default 64: largest accepted image in 32-bit words. Legal range 1..64, so the image fits the 256-byte instruction memory.
- `RELEASE_DELAY`, default 2: clock edges between checksum acceptance and CPU release. Legal range ≥1.

Ports:
- `CLK`  in  1  system clock; all state changes on its rising edge.
- `RST`  in  1  reset, asynchronous, active-high.
- `RX_DATA`  in  8  incoming stream byte.
- `RX_VALID`  in  1  `RX_DATA` is valid this cycle.
- `RX_READY`  out  1  loader accepts a byte this cycle.
- `IM_WE`  out  1  instruction-memory byte write strobe.
- `IM_ADDR`  out  8  instruction-memory byte address.
- `IM_DATA`  out  8  instruction-memory write data.
- `CPU_RST`  out  1  drives the pipeline `RST`. High means the CPU is held.
- `DONE`  out  1  image loaded and CPU released.
- `ERR`  out  1  image rejected.
- `WORDS`  out  7  word count of the current image.

## Operation
- A transfer happens on a rising edge where `RX_VALID & RX_READY` is true. No other byte is consumed.
- Stream format: one length byte N, then 4N data bytes, then one checksum byte.
  - Checksum = XOR of all 4N data bytes.
  - The length byte and the checksum byte are never written to memory.
- States: `LEN`, `LOAD`, `CHK`, `HOLD`, `RUN`, `ERR`. Reset state is `LEN`.
- `LEN`, on transfer:
  - If N==0 or N>`MAX_WORDS`: go to `ERR`.
  - Otherwise: `WORDS`←N, byte counter←0, checksum←0, go to `LOAD`.
- `LOAD`, on transfer of byte k (0-based):
  - Checksum ^= byte.
  - Next cycle: `IM_WE`=1, `IM_ADDR`=k[7:0], `IM_DATA`=byte.
  - After byte 4N−1 is transferred, go to `CHK`.
- Memory layout: byte k goes to address k, so instruction word w is {Mem[4w],Mem[4w+1],Mem[4w+2],Mem[4w+3]} (big-endian).
- `CHK`, on transfer:
  - Byte equals running checksum: go to `HOLD` and load the delay counter with `RELEASE_DELAY`−1.
  - Otherwise: go to `ERR`.
- `HOLD`: the delay counter decrements each edge. On the edge where it reads 0, go to `RUN`.
- `RUN` and `ERR` are terminal. Only `RST` leaves them.
- Combinational outputs:
  - `RX_READY` = 1 in `LEN`, `LOAD` and `CHK`; 0 otherwise.
  - `CPU_RST` = 0 only in `RUN`.
  - `DONE` = 1 only in `RUN`.
  - `ERR` = 1 only in `ERR`.
- Byte counter: 9 bits. It never wraps, because 4·`MAX_WORDS` ≤ 256. `IM_ADDR` takes the low 8 bits.

## Timing
- Reset values, applied while `RST` is high:
  - state `LEN`, `RX_READY`=1, `CPU_RST`=1;
  - `IM_WE`=0, `IM_ADDR`=0, `IM_DATA`=0;
  - `DONE`=0, `ERR`=0, `WORDS`=0;
  - internal counters and checksum = 0.
- `RST` asserted mid-operation takes effect immediately, with no clock needed. Instruction-memory contents already written are not cleared.
- Write latency: exactly 1 cycle from transfer to the `IM_WE` pulse. `IM_WE` lasts one cycle per byte. Back-to-back transfers give consecutive strobes.
- `IM_ADDR` and `IM_DATA` hold their last values when `IM_WE`=0.
- Gaps in `RX_VALID` insert gaps in `IM_WE`. Addresses stay contiguous.
- The last `IM_WE` occurs no later than the cycle the checksum byte is transferred. It therefore always precedes `CPU_RST` falling.
- Let t0 be the edge that transfers the checksum byte (`CHK`→`HOLD`). `CPU_RST` falls and `DONE` rises at edge t0+`RELEASE_DELAY`.
- `ERR` rises on the edge after the offending transfer. From that edge `RX_READY`=0.

## Test plan
- N=1; bytes 0x12, 0x34, 0x56, 0x78; checksum 0x08 -> four `IM_WE` pulses, addresses 0..3 with matching data, `WORDS`=1, `CPU_RST` falls 2 edges after the checksum transfer, `DONE`=1, `ERR`=0.
- Same image with checksum 0x09 -> `ERR`=1 on the next edge, `CPU_RST` stays 1, `RX_READY`=0, later `RX_VALID` pulses ignored.
- Length byte 0x00, then length 0x41 with `MAX_WORDS`=64 (separate runs) -> `ERR`=1, no `IM_WE` ever.
- N=2 with `RX_VALID` low for 3 cycles between bytes 2 and 3 -> no strobes during the gap, addresses 0..7 contiguous, correct release.
- `RST` pulsed after 3 data bytes of an N=2 image -> all outputs return to reset values asynchronously. A fresh full N=1 load then completes with `DONE`=1.
- N=64 with data byte k = k -> last write to address 0xFF, `WORDS`=64, checksum 0x00 accepted, `DONE`=1.

Source files
------------

// File: rtl/imem_boot_loader.sv
// Boot loader: streams a length-prefixed, XOR-checksummed image into instruction
// memory and holds the CPU pipeline in reset until the image verifies.
module imem_boot_loader #(
   parameter int MAX_WORDS     = 64,
   parameter int RELEASE_DELAY = 2
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [7:0] RX_DATA,
   input  logic       RX_VALID,
   output logic       RX_READY,
   output logic       IM_WE,
   output logic [7:0] IM_ADDR,
   output logic [7:0] IM_DATA,
   output logic       CPU_RST,
   output logic       DONE,
   output logic       ERR,
   output logic [6:0] WORDS
);

   // Wide enough to hold RELEASE_DELAY-1.
   localparam int DW = (RELEASE_DELAY > 1) ? $clog2(RELEASE_DELAY) : 1;
   localparam logic [DW-1:0] DLY_INIT = DW'(RELEASE_DELAY - 1);
   localparam logic [7:0]    MAXW     = 8'(MAX_WORDS);

   typedef enum logic [2:0] {
      S_LEN, S_LOAD, S_CHK, S_HOLD, S_RUN, S_ERR
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic [8:0]      r_cnt;
   logic [7:0]      r_csum;
   logic [6:0]      r_words;
   logic [DW-1:0]   r_dly;
   logic            r_we;
   logic [7:0]      r_addr;
   logic [7:0]      r_data;
   logic            w_xfer;
   logic            w_len_bad;
   logic            w_last;

   assign w_len_bad = (RX_DATA == 8'd0) || (RX_DATA > MAXW);
   // Byte counter reaching 4N-1 marks the final data byte.
   assign w_last    = (r_cnt == ({r_words, 2'b00} - 9'd1));
   assign w_xfer    = RX_VALID & RX_READY;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) r_state <= S_LEN;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next   = r_state;
      RX_READY = 1'b0;
      CPU_RST  = 1'b1;
      DONE     = 1'b0;
      ERR      = 1'b0;
      case (r_state)
         S_LEN: begin
            RX_READY = 1'b1;
            if (RX_VALID) w_next = w_len_bad ? S_ERR : S_LOAD;
         end
         S_LOAD: begin
            RX_READY = 1'b1;
            if (RX_VALID && w_last) w_next = S_CHK;
         end
         S_CHK: begin
            RX_READY = 1'b1;
            if (RX_VALID) w_next = (RX_DATA == r_csum) ? S_HOLD : S_ERR;
         end
         S_HOLD: begin
            if (r_dly == '0) w_next = S_RUN;
         end
         S_RUN: begin
            CPU_RST = 1'b0;
            DONE    = 1'b1;
         end
         S_ERR: begin
            ERR = 1'b1;
         end
         default: w_next = S_LEN;
      endcase
   end

   // Datapath: memory write port is registered, giving exactly one cycle of
   // latency; address and data hold between strobes.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_cnt   <= '0;
         r_csum  <= '0;
         r_words <= '0;
         r_dly   <= '0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_data  <= '0;
      end else begin
         r_we <= 1'b0;
         if (w_xfer) begin
            case (r_state)
               S_LEN: begin
                  if (!w_len_bad) begin
                     r_words <= RX_DATA[6:0];
                     r_cnt   <= '0;
                     r_csum  <= '0;
                  end
               end
               S_LOAD: begin
                  r_csum <= r_csum ^ RX_DATA;
                  r_cnt  <= r_cnt + 9'd1;
                  r_we   <= 1'b1;
                  r_addr <= r_cnt[7:0];
                  r_data <= RX_DATA;
               end
               S_CHK:   r_dly <= DLY_INIT;
               default: ;
            endcase
         end
         if (r_state == S_HOLD && r_dly != '0) r_dly <= r_dly - 1'b1;
      end
   end

   assign IM_WE   = r_we;
   assign IM_ADDR = r_addr;
   assign IM_DATA = r_data;
   assign WORDS   = r_words;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: directed scenarios plus randomized
// images checked against a stream-level reference model.
module tb_imem_boot_loader;

   localparam int MW = 64;
   localparam int RD = 2;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic [7:0] RX_DATA = 8'd0;
   logic       RX_VALID = 1'b0;
   logic       RX_READY, IM_WE, CPU_RST, DONE, ERR;
   logic [7:0] IM_ADDR, IM_DATA;
   logic [6:0] WORDS;

   int n_chk = 0;
   int n_pass = 0;
   int we_total = 0;
   logic [7:0] mem [256];

   logic       we_obs;
   logic [7:0] addr_obs, data_obs;
   int         gap_we;

   imem_boot_loader #(.MAX_WORDS(MW), .RELEASE_DELAY(RD)) dut (
      .CLK(CLK), .RST(RST), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
      .RX_READY(RX_READY), .IM_WE(IM_WE), .IM_ADDR(IM_ADDR), .IM_DATA(IM_DATA),
      .CPU_RST(CPU_RST), .DONE(DONE), .ERR(ERR), .WORDS(WORDS)
   );

   always #5 CLK = ~CLK;

   // Instruction-memory model, sampled mid-cycle.
   always @(negedge CLK) begin
      if (IM_WE) begin
         mem[IM_ADDR] = IM_DATA;
         we_total++;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached, checks so far %0d", n_chk);
      $fatal(1);
   end

   // Driver only: idles `gap` cycles, then offers one byte for one edge and
   // records what the write port shows one cycle later.
   task automatic xfer(input logic [7:0] b, input int gap);
      gap_we = 0;
      RX_VALID = 1'b0;
      repeat (gap) begin
         RX_DATA = 8'($urandom);
         @(posedge CLK); #1;
         if (IM_WE) gap_we++;
      end
      RX_DATA = b;
      RX_VALID = 1'b1;
      @(posedge CLK); #1;
      RX_VALID = 1'b0;
      we_obs = IM_WE;
      addr_obs = IM_ADDR;
      data_obs = IM_DATA;
   endtask

   task automatic apply_reset();
      RX_VALID = 1'b0;
      RST = 1'b1;
      #2;
      RST = 1'b0;
      @(posedge CLK); #1;
   endtask

   task automatic test_reset();
      #1;
      n_chk++;
      if ({RX_READY, IM_WE, IM_ADDR, IM_DATA, CPU_RST, DONE, ERR, WORDS} !== {1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 7'd0})
         $display("FAIL reset_values: got rdy=%b we=%b addr=%h data=%h cpurst=%b done=%b err=%b words=%0d, want 1 0 00 00 1 0 0 0",
                  RX_READY, IM_WE, IM_ADDR, IM_DATA, CPU_RST, DONE, ERR, WORDS);
      else n_pass++;
      #2;
      RST = 1'b0;
      @(posedge CLK); #1;
   endtask

   task automatic test_n1_good();
      logic [7:0] d[$] = '{8'h12, 8'h34, 8'h56, 8'h78};
      apply_reset();
      xfer(8'd1, 0);
      foreach (d[k]) begin
         xfer(d[k], 0);
         n_chk++;
         if ({we_obs, addr_obs, data_obs} !== {1'b1, 8'(k), d[k]})
            $display("FAIL n1_write%0d: got we=%b addr=%h data=%h, want 1 %h %h", k, we_obs, addr_obs, data_obs, 8'(k), d[k]);
         else n_pass++;
      end
      xfer(8'h08, 0);
      for (int e = 0; e < RD; e++) begin
         n_chk++;
         if (CPU_RST !== 1'b1) $display("FAIL n1_hold_t0+%0d: CPU_RST=%b want 1", e, CPU_RST);
         else n_pass++;
         @(posedge CLK); #1;
      end
      n_chk++;
      if ({CPU_RST, DONE, ERR, WORDS} !== {1'b0, 1'b1, 1'b0, 7'd1})
         $display("FAIL n1_release: got cpurst=%b done=%b err=%b words=%0d, want 0 1 0 1", CPU_RST, DONE, ERR, WORDS);
      else n_pass++;
   endtask

   task automatic test_bad_cks();
      int wt;
      apply_reset();
      xfer(8'd1, 0);
      xfer(8'h12, 0); xfer(8'h34, 0); xfer(8'h56, 0); xfer(8'h78, 0);
      xfer(8'h09, 0);
      n_chk++;
      if ({ERR, RX_READY, CPU_RST, DONE} !== 4'b1010)
         $display("FAIL bad_cks_err: got err=%b rdy=%b cpurst=%b done=%b, want 1 0 1 0", ERR, RX_READY, CPU_RST, DONE);
      else n_pass++;
      wt = we_total;
      RX_VALID = 1'b1;
      repeat (5) begin RX_DATA = 8'($urandom); @(posedge CLK); end
      #1; RX_VALID = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      n_chk++;
      if ({we_total - wt, ERR, CPU_RST} !== {32'd0, 1'b1, 1'b1})
         $display("FAIL bad_cks_ignore: got extra_writes=%0d err=%b cpurst=%b, want 0 1 1", we_total - wt, ERR, CPU_RST);
      else n_pass++;
   endtask

   task automatic test_bad_len();
      logic [7:0] lens[$] = '{8'h00, 8'(MW + 1)};
      int wt;
      foreach (lens[i]) begin
         apply_reset();
         wt = we_total;
         xfer(lens[i], 0);
         n_chk++;
         if ({ERR, RX_READY, CPU_RST} !== 3'b101)
            $display("FAIL bad_len_%h: got err=%b rdy=%b cpurst=%b, want 1 0 1", lens[i], ERR, RX_READY, CPU_RST);
         else n_pass++;
         RX_VALID = 1'b1;
         repeat (6) begin RX_DATA = 8'($urandom); @(posedge CLK); end
         #1; RX_VALID = 1'b0;
         @(posedge CLK); #1;
         n_chk++;
         if (we_total != wt) $display("FAIL bad_len_nowrite_%h: got writes=%0d want 0", lens[i], we_total - wt);
         else n_pass++;
      end
   endtask

   task automatic test_gap();
      logic [7:0] d[8];
      logic [7:0] cks = 8'h00;
      apply_reset();
      foreach (d[k]) begin d[k] = 8'($urandom); cks ^= d[k]; end
      xfer(8'd2, 0);
      foreach (d[k]) begin
         xfer(d[k], (k == 3) ? 3 : 0);
         n_chk++;
         if ({gap_we, we_obs, addr_obs, data_obs} !== {32'd0, 1'b1, 8'(k), d[k]})
            $display("FAIL gap_write%0d: got gap_strobes=%0d we=%b addr=%h data=%h, want 0 1 %h %h",
                     k, gap_we, we_obs, addr_obs, data_obs, 8'(k), d[k]);
         else n_pass++;
      end
      xfer(cks, 0);
      repeat (RD) @(posedge CLK);
      #1;
      n_chk++;
      if ({CPU_RST, DONE, WORDS} !== {1'b0, 1'b1, 7'd2})
         $display("FAIL gap_release: got cpurst=%b done=%b words=%0d, want 0 1 2", CPU_RST, DONE, WORDS);
      else n_pass++;
   endtask

   task automatic test_async_rst();
      logic [7:0] d[4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      apply_reset();
      xfer(8'd2, 0);
      xfer(8'hA1, 0); xfer(8'hA2, 0); xfer(8'hA3, 0);
      RST = 1'b1;
      #1;
      n_chk++;
      if ({RX_READY, IM_WE, IM_ADDR, IM_DATA, CPU_RST, DONE, ERR, WORDS} !== {1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 7'd0})
         $display("FAIL async_rst: got rdy=%b we=%b addr=%h data=%h cpurst=%b done=%b err=%b words=%0d, want 1 0 00 00 1 0 0 0",
                  RX_READY, IM_WE, IM_ADDR, IM_DATA, CPU_RST, DONE, ERR, WORDS);
      else n_pass++;
      #1;
      RST = 1'b0;
      @(posedge CLK); #1;
      xfer(8'd1, 0);
      foreach (d[k]) xfer(d[k], 0);
      xfer(8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF, 0);
      repeat (RD) @(posedge CLK);
      #1;
      n_chk++;
      if ({DONE, CPU_RST, WORDS, mem[0], mem[1], mem[2], mem[3]} !== {1'b1, 1'b0, 7'd1, d[0], d[1], d[2], d[3]})
         $display("FAIL async_reload: got done=%b cpurst=%b words=%0d mem=%h%h%h%h, want 1 0 1 deadbeef",
                  DONE, CPU_RST, WORDS, mem[0], mem[1], mem[2], mem[3]);
      else n_pass++;
   endtask

   task automatic test_full();
      int bad = 0;
      apply_reset();
      xfer(8'(MW), 0);
      for (int k = 0; k < 4 * MW; k++) begin
         xfer(8'(k), 0);
         if ({we_obs, addr_obs, data_obs} !== {1'b1, 8'(k), 8'(k)}) bad++;
      end
      n_chk++;
      if (bad != 0 || addr_obs !== 8'hFF)
         $display("FAIL full_writes: got bad_strobes=%0d last_addr=%h, want 0 ff", bad, addr_obs);
      else n_pass++;
      xfer(8'h00, 0);
      repeat (RD) @(posedge CLK);
      #1;
      n_chk++;
      if ({DONE, ERR, WORDS} !== {1'b1, 1'b0, 7'd64})
         $display("FAIL full_release: got done=%b err=%b words=%0d, want 1 0 64", DONE, ERR, WORDS);
      else n_pass++;
   endtask

   // Reference model: memory gets data byte k at address k; the image is
   // accepted iff the trailing byte equals the XOR of all data bytes.
   task automatic test_random();
      for (int it = 0; it < 6; it++) begin
         int n = $urandom_range(1, MW);
         logic [7:0] d[$];
         logic [7:0] x = 8'h00;
         logic [7:0] cks;
         bit corrupt = ($urandom_range(0, 2) == 0);
         int bad = 0;
         int mbad = 0;
         for (int k = 0; k < 4 * n; k++) begin
            d.push_back(8'($urandom));
            x ^= d[k];
         end
         cks = corrupt ? (x ^ (8'h01 << $urandom_range(0, 7))) : x;
         apply_reset();
         xfer(8'(n), $urandom_range(0, 2));
         foreach (d[k]) begin
            xfer(d[k], ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
            if ({gap_we, we_obs, addr_obs, data_obs} !== {32'd0, 1'b1, 8'(k), d[k]}) bad++;
         end
         n_chk++;
         if (bad != 0) $display("FAIL rand%0d_strobes: got %0d bad strobes of %0d, want 0", it, bad, 4 * n);
         else n_pass++;
         xfer(cks, 0);
         repeat (RD) @(posedge CLK);
         #1;
         foreach (d[k]) if (mem[k] !== d[k]) mbad++;
         n_chk++;
         if ({mbad, WORDS, DONE, ERR, CPU_RST} !== {32'd0, 7'(n), !corrupt, corrupt, corrupt})
            $display("FAIL rand%0d_result: got mem_errs=%0d words=%0d done=%b err=%b cpurst=%b, want 0 %0d %b %b %b",
                     it, mbad, WORDS, DONE, ERR, CPU_RST, n, !corrupt, corrupt, corrupt);
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_n1_good();
      test_bad_cks();
      test_bad_len();
      test_gap();
      test_async_rst();
      test_full();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
